// File: rtl/ap_pkg.sv
// Shared definitions for the AP pointer stage and the AP register bank:
// op codes, default geometry and the bank's swap-sequencer state encoding.
package ap_pkg;

    localparam int AP_NREG = 9;
    localparam int AP_DW   = 8;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_INC  = 3'b010,
        OP_DEC  = 3'b011,
        OP_CLR  = 3'b100,
        OP_SWAP = 3'b101,
        OP_RSV6 = 3'b110,
        OP_RSV7 = 3'b111
    } ap_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SWAP_RD = 2'd1,
        ST_SWAP_WR = 2'd2
    } ap_state_e;

    // Ops that modify a register in a single cycle and update Zero/Carry.
    function automatic logic is_single_write(input ap_op_e op);
        return (op == OP_LOAD) || (op == OP_INC) || (op == OP_DEC) || (op == OP_CLR);
    endfunction

endpackage

// File: rtl/ap_alu.sv
// Combinational result/flag generator for LOAD, INC, DEC and CLR.
module ap_alu
    import ap_pkg::*;
#(
    parameter int DW = AP_DW
) (
    input  ap_op_e        op,
    input  logic [DW-1:0] operand,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] result,
    output logic          zero,
    output logic          carry
);

    always_comb begin
        result = operand;
        carry  = 1'b0;
        case (op)
            OP_LOAD: result = din;
            OP_INC:  {carry, result} = {1'b0, operand} + (DW+1)'(1);
            OP_DEC: begin
                result = operand - DW'(1);
                carry  = (operand == '0);   // borrow out of zero
            end
            OP_CLR:  result = '0;
            default: ;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/ap_reg_bank.sv
// Pointer-addressed register bank with single-cycle arithmetic ops and a
// two-cycle SWAP against register 0, plus registered status flags.
module ap_reg_bank
    import ap_pkg::*;
#(
    parameter int NREG = AP_NREG,
    parameter int DW   = AP_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    APSel,
    input  logic          OpValid,
    input  logic [2:0]    Op,
    input  logic [DW-1:0] DIn,
    output logic [DW-1:0] DOut,
    output logic          Zero,
    output logic          Carry,
    output logic          Busy,
    output logic          SelErr
);

    logic [DW-1:0] regs [NREG];

    ap_state_e     state_reg, state_next;
    logic [3:0]    swap_sel_reg;
    logic [DW-1:0] swap_a_reg, swap_b_reg;
    logic          busy_reg, zero_reg, carry_reg, sel_err_reg;
    logic [DW-1:0] dout_reg;

    ap_op_e        op_code;
    logic          sel_ok, accept, op_real, wr_single, swap_start;
    logic [DW-1:0] rd_val, alu_result;
    logic          alu_zero, alu_carry;

    assign op_code    = ap_op_e'(Op);
    assign sel_ok     = (int'(APSel) < NREG);
    assign accept     = OpValid && !busy_reg;
    assign op_real    = is_single_write(op_code) || (op_code == OP_SWAP);
    assign wr_single  = accept && sel_ok && is_single_write(op_code);
    // SWAP of register 0 with itself is a no-op and never enters the sequencer.
    assign swap_start = accept && sel_ok && (op_code == OP_SWAP) && (APSel != 4'd0);

    always_comb begin
        rd_val = '0;
        if (sel_ok) begin
            rd_val = regs[APSel];
        end
    end

    ap_alu #(.DW(DW)) u_alu (
        .op      (op_code),
        .operand (rd_val),
        .din     (DIn),
        .result  (alu_result),
        .zero    (alu_zero),
        .carry   (alu_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (swap_start) state_next = ST_SWAP_RD;
            ST_SWAP_RD: state_next = ST_SWAP_WR;
            ST_SWAP_WR: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Storage: single-cycle writes and the swap write-back never coincide,
    // because no op is accepted while the sequencer is busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_single) begin
            regs[APSel] <= alu_result;
        end else if (state_reg == ST_SWAP_WR) begin
            regs[swap_sel_reg] <= swap_b_reg;
            regs[0]            <= swap_a_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg     <= 1'b0;
            swap_sel_reg <= '0;
            swap_a_reg   <= '0;
            swap_b_reg   <= '0;
            zero_reg     <= 1'b0;
            carry_reg    <= 1'b0;
            sel_err_reg  <= 1'b0;
            dout_reg     <= '0;
        end else begin
            busy_reg    <= (state_next != ST_IDLE);
            sel_err_reg <= accept && op_real && !sel_ok;
            dout_reg    <= rd_val;
            if (swap_start) begin
                swap_sel_reg <= APSel;
            end
            if (state_reg == ST_SWAP_RD) begin
                swap_a_reg <= regs[swap_sel_reg];
                swap_b_reg <= regs[0];
            end
            if (wr_single) begin
                zero_reg  <= alu_zero;
                carry_reg <= alu_carry;
            end
        end
    end

    assign DOut   = dout_reg;
    assign Zero   = zero_reg;
    assign Carry  = carry_reg;
    assign Busy   = busy_reg;
    assign SelErr = sel_err_reg;

endmodule

// File: tb/tb_ap_reg_bank.sv
// Directed bench for ap_reg_bank: inputs change and outputs are sampled on
// the falling edge, so each step covers exactly one rising edge.
module tb_ap_reg_bank;

    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] LOAD = 3'b001;
    localparam logic [2:0] INC  = 3'b010;
    localparam logic [2:0] DEC  = 3'b011;
    localparam logic [2:0] CLR  = 3'b100;
    localparam logic [2:0] SWAP = 3'b101;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] APSel = '0;
    logic       OpValid = 1'b0;
    logic [2:0] Op = '0;
    logic [7:0] DIn = '0;
    logic [7:0] DOut;
    logic       Zero, Carry, Busy, SelErr;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_regs [9];

    ap_reg_bank #(.NREG(9), .DW(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .APSel   (APSel),
        .OpValid (OpValid),
        .Op      (Op),
        .DIn     (DIn),
        .DOut    (DOut),
        .Zero    (Zero),
        .Carry   (Carry),
        .Busy    (Busy),
        .SelErr  (SelErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic do_op(input logic [3:0] sel, input logic [2:0] code, input logic [7:0] d);
        APSel   = sel;
        Op      = code;
        DIn     = d;
        OpValid = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_idle(input logic [3:0] sel);
        APSel   = sel;
        Op      = NOP;
        DIn     = '0;
        OpValid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_dout",   32'(DOut),   32'h0);
        chk("rst_zero",   32'(Zero),   32'h0);
        chk("rst_carry",  32'(Carry),  32'h0);
        chk("rst_busy",   32'(Busy),   32'h0);
        chk("rst_selerr", 32'(SelErr), 32'h0);
        rst = 1'b0;

        // LOAD then read back two edges later
        do_op(4'd3, LOAD, 8'h5A);
        chk("load_pre_dout", 32'(DOut), 32'h0);
        do_idle(4'd3);
        chk("load_dout",  32'(DOut),  32'h5A);
        chk("load_zero",  32'(Zero),  32'h0);
        chk("load_carry", 32'(Carry), 32'h0);

        // INC/DEC wrap and flags
        do_op(4'd8, LOAD, 8'hFF);
        do_op(4'd8, INC, 8'h00);
        chk("inc_zero",  32'(Zero),  32'h1);
        chk("inc_carry", 32'(Carry), 32'h1);
        do_op(4'd8, DEC, 8'h00);
        chk("dec_pre_dout", 32'(DOut),  32'h00);
        chk("dec_zero",     32'(Zero),  32'h0);
        chk("dec_carry",    32'(Carry), 32'h1);
        do_idle(4'd8);
        chk("dec_dout", 32'(DOut), 32'hFF);
        do_op(4'd8, DEC, 8'h00);
        chk("dec2_carry", 32'(Carry), 32'h0);
        do_op(4'd8, CLR, 8'h00);
        chk("clr_zero",  32'(Zero),  32'h1);
        chk("clr_carry", 32'(Carry), 32'h0);
        do_idle(4'd8);
        chk("clr_dout", 32'(DOut), 32'h00);

        // SWAP with ops dropped while busy
        do_op(4'd0, LOAD, 8'h11);
        do_op(4'd5, LOAD, 8'h22);
        do_op(4'd2, LOAD, 8'h33);
        do_op(4'd7, CLR, 8'h00);
        chk("pre_swap_zero", 32'(Zero), 32'h1);
        do_op(4'd5, SWAP, 8'h00);
        chk("swap_busy1", 32'(Busy), 32'h1);
        do_op(4'd2, LOAD, 8'h99);
        chk("swap_busy2", 32'(Busy), 32'h1);
        do_op(4'd2, LOAD, 8'h99);
        chk("swap_busy3", 32'(Busy), 32'h0);
        do_idle(4'd0);
        chk("swap_zero_hold", 32'(Zero), 32'h1);
        chk("swap_reg0", 32'(DOut), 32'h22);
        do_idle(4'd5);
        chk("swap_reg5", 32'(DOut), 32'h11);
        do_idle(4'd2);
        chk("swap_reg2", 32'(DOut), 32'h33);
        do_op(4'd0, SWAP, 8'h00);
        chk("swap0_busy", 32'(Busy), 32'h0);
        do_idle(4'd0);
        chk("swap0_busy2", 32'(Busy), 32'h0);

        // Out-of-range selects
        do_op(4'd9, LOAD, 8'h77);
        chk("sel9_err",  32'(SelErr), 32'h1);
        chk("sel9_dout", 32'(DOut),   32'h0);
        do_idle(4'd9);
        chk("sel9_err_end", 32'(SelErr), 32'h0);
        do_op(4'd15, LOAD, 8'h77);
        chk("sel15_err",  32'(SelErr), 32'h1);
        chk("sel15_dout", 32'(DOut),   32'h0);
        do_idle(4'd0);
        chk("sel15_err_end", 32'(SelErr), 32'h0);
        chk("sel_zero_hold", 32'(Zero), 32'h1);
        exp_regs = '{8'h22, 8'h00, 8'h33, 8'h5A, 8'h00, 8'h11, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 9; i++) begin
            do_idle(4'(i));
            chk($sformatf("keep_reg%0d", i), 32'(DOut), 32'(exp_regs[i]));
        end

        // Reset during SWAP_RD
        do_op(4'd5, SWAP, 8'h00);
        chk("rsw_busy", 32'(Busy), 32'h1);
        chk("rsw_dout", 32'(DOut), 32'h11);
        #2 rst = 1'b1;
        #1;
        chk("arst_dout",   32'(DOut),   32'h0);
        chk("arst_busy",   32'(Busy),   32'h0);
        chk("arst_zero",   32'(Zero),   32'h0);
        chk("arst_carry",  32'(Carry),  32'h0);
        chk("arst_selerr", 32'(SelErr), 32'h0);
        OpValid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        do_op(4'd1, LOAD, 8'h3C);
        do_idle(4'd0);
        chk("arst_reg0", 32'(DOut), 32'h0);
        chk("arst_busy2", 32'(Busy), 32'h0);
        do_idle(4'd5);
        chk("arst_reg5", 32'(DOut), 32'h0);
        do_idle(4'd1);
        chk("arst_first_op", 32'(DOut), 32'h3C);

        // Sweep write then sweep read
        for (int i = 0; i < 9; i++) begin
            do_op(4'(i), LOAD, 8'(i));
        end
        for (int i = 0; i < 9; i++) begin
            do_idle(4'(i));
            chk($sformatf("sweep_reg%0d", i), 32'(DOut), 32'(i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
